ff_mem_march_bist: RTL and testbench
====================================

Name: ff_mem_march_bist

Overview:
- Built-in self-test initiator for the flip-flop register-file memory. It drives that memory's address, read_en, write_en and write_data port, and checks its read_data.
- Runs a fixed March C- sequence over every word, using all-zeros and all-ones backgrounds. It reports pass/fail, the first failing address and March element, and a saturating mismatch count.
- Sits between the SoC test controller (start/done handshake) and one memory instance, muxed in ahead of functional traffic.

Parameters:
- WIDTH, 1024, memory word width in bits.
- DEPTH, 512, number of words; any value >= 2, not necessarily a power of 2.
- ERR_W, 16, width of the mismatch counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle test request.
- busy  output  1  test sequence in progress.
- done  output  1  test finished; held until the next accepted start.
- fail  output  1  sticky flag: at least one mismatch seen.
- fail_addr  output  $clog2(DEPTH)  address of the first mismatch.
- fail_elem  output  3  March element index (0-5) of the first mismatch.
- err_count  output  ERR_W  total mismatches, saturating.
- mem_address  output  $clog2(DEPTH)  memory address.
- mem_read_en  output  1  memory read enable.
- mem_write_en  output  1  memory write enable.
- mem_write_data  output  WIDTH  memory write data.
- mem_read_data  input  WIDTH  memory read data; combinational, valid in the same cycle as mem_read_en/mem_address.

Behaviour:
- Reset (rst low, any time including mid-test): FSM returns to IDLE. All outputs are 0: busy, done, fail, fail_addr, fail_elem, err_count, mem_address, mem_read_en, mem_write_en, mem_write_data.
- All mem_* outputs and status outputs are driven directly from flops.
- FSM states: IDLE, RUN, DONE.
- start handling:
  - Sampled high in IDLE or DONE: next cycle enters RUN with element 0 and address 0.
  - On that edge, clears done, fail, fail_addr, fail_elem and err_count, and sets busy.
  - start while in RUN is ignored.
- March elements, with B = all zeros and ~B = all ones:
  - E0: ascending, write B.
  - E1: ascending, read expecting B, then write ~B.
  - E2: ascending, read expecting ~B, then write B.
  - E3: descending, read expecting B, then write ~B.
  - E4: descending, read expecting ~B, then write B.
  - E5: ascending, read expecting B.
- Ascending order is 0..DEPTH-1; descending is DEPTH-1..0. No address beyond DEPTH-1 is ever driven.
- Per-cycle operation:
  - Write-only and read-only elements take 1 cycle per address.
  - Read-then-write elements take 2 cycles per address: a read cycle, then a write cycle at the same address.
  - Exactly one of mem_read_en/mem_write_en is high in every RUN cycle; both are low in IDLE and DONE.
  - mem_write_data is 0 when no write is in progress.
- Element transitions: after the last address of an element, the next cycle starts the following element at its first address (0 for ascending, DEPTH-1 for descending). There are no idle gaps.
- Total RUN length is exactly 10*DEPTH cycles. busy is high for exactly those cycles.
- Compare:
  - In each read cycle, mem_read_data is compared against the expected background.
  - On mismatch, at the next edge: fail is set, and err_count increments, saturating at all ones.
  - If fail was previously 0, fail_addr and fail_elem capture the current address and element. Later mismatches do not change them.
- Completion: the edge ending the final E5 read moves the FSM to DONE. busy drops and done rises on that same edge; a mismatch on that final read is still recorded.
- In DONE, status outputs hold until start or reset.
- Simultaneous events: a mismatch on the final read is recorded together with entry to DONE. Reset overrides everything.

Test Plan:
- Clean run (WIDTH=8, DEPTH=8, fault-free memory model): pulse start → busy high for exactly 80 cycles; then done=1, fail=0, err_count=0. The trace shows the E0 writes at addresses 0..7, then the E1 read/write pairs at 0..7, and E3 starting at address 7.
- Stuck-at-0 on bit 0 of address 5 → after completion fail=1, fail_addr=5, fail_elem=2, err_count=2 (E2 and E4 mismatches).
- Stuck-at-1 on bit 7 of address 0 → fail_elem=1, fail_addr=0, err_count=3 (E1, E3, E5).
- start pulsed while busy (cycle 20) → ignored; busy still totals 80 cycles. start in DONE after a failing run → status clears, and a fault-free rerun ends with fail=0.
- rst asserted at cycle 37 of the run → busy, mem_read_en, mem_write_en and the status outputs go to 0 immediately. After release, a new start runs the full 80-cycle sequence.
- DEPTH=5, WIDTH=4 → mem_address never exceeds 4; busy lasts 50 cycles; descending elements start at address 4.

Source files
------------

// File: rtl/ff_mem_march_bist.sv
// March C- self-test initiator for the flip-flop register-file memory.
// Walks six March elements over every word using all-zeros and all-ones
// backgrounds, and drives the memory port from flops. The first failing
// address/element and a saturating mismatch count are kept as sticky status.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | March sequence in progress, one memory operation per cycle
// DONE  | sequence finished, status held until the next start
module ff_mem_march_bist #(
    parameter int WIDTH = 1024,
    parameter int DEPTH = 512,
    parameter int ERR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [$clog2(DEPTH)-1:0] fail_addr,
    output logic [2:0]               fail_elem,
    output logic [ERR_W-1:0]         err_count,
    output logic [$clog2(DEPTH)-1:0] mem_address,
    output logic                     mem_read_en,
    output logic                     mem_write_en,
    output logic [WIDTH-1:0]         mem_write_data,
    input  logic [WIDTH-1:0]         mem_read_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]    ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0]    ADDR_ONE  = AW'(1);
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic [AW-1:0]     addr_d;
    logic              rd_d, wr_d;
    logic [WIDTH-1:0]  wdata_d;
    logic              busy_d, done_d, fail_d;
    logic [AW-1:0]     fail_addr_d;
    logic [2:0]        fail_elem_d;
    logic [ERR_W-1:0]  err_d;

    logic              rw_elem, desc_elem, last_addr, mismatch;
    logic [WIDTH-1:0]  exp_data, rw_wdata;

    // Element attributes, the read background and the mismatch decision
    always_comb begin
        rw_elem   = (elem_q >= 3'd1) && (elem_q <= 3'd4);
        desc_elem = (elem_q == 3'd3) || (elem_q == 3'd4);
        exp_data  = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
        rw_wdata  = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? '1 : '0;
        last_addr = desc_elem ? (mem_address == '0) : (mem_address == ADDR_LAST);
        mismatch  = (state_q == RUN) && mem_read_en && (mem_read_data != exp_data);
    end

    // Next-state, next memory operation and status update
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = mem_address;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        wdata_d     = '0;
        busy_d      = busy;
        done_d      = done;
        fail_d      = fail;
        fail_addr_d = fail_addr;
        fail_elem_d = fail_elem;
        err_d       = err_count;

        if (mismatch) begin
            fail_d = 1'b1;
            if (err_count != '1) begin
                err_d = err_count + ERR_ONE;
            end
            if (!fail) begin
                fail_addr_d = mem_address;
                fail_elem_d = elem_q;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    elem_d      = 3'd0;
                    addr_d      = '0;
                    wr_d        = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = 3'd0;
                    err_d       = '0;
                end
            end
            RUN: begin
                if (mem_read_en && rw_elem) begin
                    // second half of a read-then-write pair, same address
                    wr_d    = 1'b1;
                    wdata_d = rw_wdata;
                end else if (!last_addr) begin
                    addr_d = desc_elem ? (mem_address - ADDR_ONE) : (mem_address + ADDR_ONE);
                    if (elem_q == 3'd0) begin
                        wr_d = 1'b1;
                    end else begin
                        rd_d = 1'b1;
                    end
                end else if (elem_q == 3'd5) begin
                    state_d = DONE;
                    elem_d  = 3'd0;
                    addr_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // elements 1..5 all open with a read
                    elem_d = elem_q + 3'd1;
                    addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_LAST : '0;
                    rd_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, memory port and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            elem_q         <= 3'd0;
            mem_address    <= '0;
            mem_read_en    <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_write_data <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            fail_addr      <= '0;
            fail_elem      <= 3'd0;
            err_count      <= '0;
        end else begin
            state_q        <= state_d;
            elem_q         <= elem_d;
            mem_address    <= addr_d;
            mem_read_en    <= rd_d;
            mem_write_en   <= wr_d;
            mem_write_data <= wdata_d;
            busy           <= busy_d;
            done           <= done_d;
            fail           <= fail_d;
            fail_addr      <= fail_addr_d;
            fail_elem      <= fail_elem_d;
            err_count      <= err_d;
        end
    end
endmodule

// File: tb/tb_ff_mem_march_bist.sv
// Bench for ff_mem_march_bist: two instances (8x8 and 5x4) each with a
// behavioural memory. Stimulus pushes the expected operation trace and final
// status into queues; per-instance monitors pop and compare on the falling edge.
module tb_ff_mem_march_bist;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start8, start5;

    logic       busy8, done8, fail8, rd8, wr8;
    logic [2:0] faddr8, felem8, ma8;
    logic [15:0] err8;
    logic [7:0] mwd8, mrd8;

    logic       busy5, done5, fail5, rd5, wr5;
    logic [2:0] faddr5, felem5, ma5;
    logic [15:0] err5;
    logic [3:0] mwd5, mrd5;

    logic       f_en;
    logic [2:0] f_addr, f_bit;
    logic       f_val;

    logic [7:0] m8 [8];
    logic [3:0] m5 [5];

    ff_mem_march_bist #(.WIDTH(8), .DEPTH(8), .ERR_W(16)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
        .fail(fail8), .fail_addr(faddr8), .fail_elem(felem8), .err_count(err8),
        .mem_address(ma8), .mem_read_en(rd8), .mem_write_en(wr8),
        .mem_write_data(mwd8), .mem_read_data(mrd8)
    );

    ff_mem_march_bist #(.WIDTH(4), .DEPTH(5), .ERR_W(16)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .busy(busy5), .done(done5),
        .fail(fail5), .fail_addr(faddr5), .fail_elem(felem5), .err_count(err5),
        .mem_address(ma5), .mem_read_en(rd5), .mem_write_en(wr5),
        .mem_write_data(mwd5), .mem_read_data(mrd5)
    );

    // Memory models with an optional stuck-at bit on the 8-word instance
    always @(posedge clk) begin
        if (wr8) m8[ma8] <= mwd8;
        if (wr5 && ma5 < 3'd5) m5[ma5] <= mwd5;
    end

    always_comb begin
        mrd8 = m8[ma8];
        if (f_en && ma8 == f_addr) mrd8[f_bit] = f_val;
        mrd5 = (ma5 < 3'd5) ? m5[ma5] : 4'h0;
    end

    typedef struct { logic rd; logic wr; int addr; logic [7:0] wdata; } op_t;
    typedef struct { logic fail; int faddr; int felem; int err; int cycles; } res_t;

    op_t  tr8[$], tr5[$];
    res_t ex8[$], ex5[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cnt8 = 0, cnt5 = 0;
    logic done8_d = 1'b0, done5_d = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event missing", name);
    endtask

    // Expected March C- operation trace for one run
    task automatic push_trace(input int inst, input int depth, input logic [7:0] ones);
        op_t o;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < depth; k++) begin
                o.addr = (e == 3 || e == 4) ? depth - 1 - k : k;
                o.wdata = 8'h00;
                if (e == 0) begin
                    o.rd = 1'b0; o.wr = 1'b1;
                    if (inst == 8) tr8.push_back(o); else tr5.push_back(o);
                end else begin
                    o.rd = 1'b1; o.wr = 1'b0;
                    if (inst == 8) tr8.push_back(o); else tr5.push_back(o);
                    if (e != 5) begin
                        o.rd = 1'b0; o.wr = 1'b1;
                        o.wdata = (e == 1 || e == 3) ? ones : 8'h00;
                        if (inst == 8) tr8.push_back(o); else tr5.push_back(o);
                    end
                end
            end
        end
    endtask

    task automatic push_res(input int inst, input logic f, input int fa, input int fe,
                            input int er, input int cyc);
        res_t r;
        r.fail = f; r.faddr = fa; r.felem = fe; r.err = er; r.cycles = cyc;
        if (inst == 8) ex8.push_back(r); else ex5.push_back(r);
    endtask

    // Monitor for the 8-word instance
    always @(negedge clk) begin
        op_t  o;
        res_t r;
        if (!rst) begin
            tr8.delete();
            cnt8 = 0;
            done8_d = 1'b0;
        end else begin
            if (busy8) begin
                cnt8++;
                if (tr8.size() == 0) flag_fail("trace8_extra_op");
                else begin
                    o = tr8.pop_front();
                    chk("trace8_rd", rd8, o.rd);
                    chk("trace8_wr", wr8, o.wr);
                    chk("trace8_addr", ma8, o.addr);
                    chk("trace8_wdata", mwd8, o.wdata);
                end
            end else begin
                chk("idle8_enables", {rd8, wr8}, 2'b00);
            end
            if (done8 && !done8_d) begin
                if (ex8.size() == 0) flag_fail("result8_unexpected");
                else begin
                    r = ex8.pop_front();
                    chk("res8_fail", fail8, r.fail);
                    chk("res8_fail_addr", faddr8, r.faddr);
                    chk("res8_fail_elem", felem8, r.felem);
                    chk("res8_err_count", err8, r.err);
                    chk("res8_busy_cycles", cnt8, r.cycles);
                end
                cnt8 = 0;
            end
            done8_d = done8;
        end
    end

    // Monitor for the 5-word instance
    always @(negedge clk) begin
        op_t  o;
        res_t r;
        if (!rst) begin
            tr5.delete();
            cnt5 = 0;
            done5_d = 1'b0;
        end else begin
            if (busy5) begin
                cnt5++;
                chk("addr5_in_range", ma5 <= 3'd4, 1'b1);
                if (tr5.size() == 0) flag_fail("trace5_extra_op");
                else begin
                    o = tr5.pop_front();
                    chk("trace5_rd", rd5, o.rd);
                    chk("trace5_wr", wr5, o.wr);
                    chk("trace5_addr", ma5, o.addr);
                    chk("trace5_wdata", mwd5, o.wdata);
                end
            end else begin
                chk("idle5_enables", {rd5, wr5}, 2'b00);
            end
            if (done5 && !done5_d) begin
                if (ex5.size() == 0) flag_fail("result5_unexpected");
                else begin
                    r = ex5.pop_front();
                    chk("res5_fail", fail5, r.fail);
                    chk("res5_err_count", err5, r.err);
                    chk("res5_busy_cycles", cnt5, r.cycles);
                end
                cnt5 = 0;
            end
            done5_d = done5;
        end
    end

    task automatic pulse8();
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
    endtask

    task automatic pulse5();
        @(posedge clk); #1 start5 = 1'b1;
        @(posedge clk); #1 start5 = 1'b0;
    endtask

    task automatic wait_done(input int inst);
        int n;
        n = 0;
        while (((inst == 8) ? done8 : done5) !== 1'b1 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) flag_fail(inst == 8 ? "done8_timeout" : "done5_timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; start8 = 1'b0; start5 = 1'b0;
        f_en = 1'b0; f_addr = 3'd0; f_bit = 3'd0; f_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset8_busy", busy8, 1'b0);
        chk("reset8_done", done8, 1'b0);
        chk("reset8_status", {fail8, faddr8, felem8, err8}, 0);
        chk("reset8_mem", {ma8, rd8, wr8, mwd8}, 0);
        chk("reset5_all", {busy5, done5, fail5, err5, ma5, rd5, wr5, mwd5}, 0);
        rst = 1'b1;

        // clean run
        push_trace(8, 8, 8'hFF);
        push_res(8, 1'b0, 0, 0, 0, 80);
        pulse8();
        wait_done(8);
        repeat (3) @(posedge clk);
        #1;
        chk("done8_held", done8, 1'b1);
        chk("busy8_after_done", busy8, 1'b0);

        // stuck-at-0 on bit 0 of word 5
        f_en = 1'b1; f_addr = 3'd5; f_bit = 3'd0; f_val = 1'b0;
        push_trace(8, 8, 8'hFF);
        push_res(8, 1'b1, 5, 2, 2, 80);
        pulse8();
        wait_done(8);

        // stuck-at-1 on bit 7 of word 0
        f_addr = 3'd0; f_bit = 3'd7; f_val = 1'b1;
        push_trace(8, 8, 8'hFF);
        push_res(8, 1'b1, 0, 1, 3, 80);
        pulse8();
        wait_done(8);
        repeat (2) @(posedge clk);
        #1;
        chk("fail8_held_in_done", fail8, 1'b1);

        // start from a failing DONE clears status; start while busy is ignored
        f_en = 1'b0;
        push_trace(8, 8, 8'hFF);
        push_res(8, 1'b0, 0, 0, 0, 80);
        pulse8();
        chk("restart8_fail_clear", fail8, 1'b0);
        chk("restart8_err_clear", err8, 16'd0);
        chk("restart8_done_clear", done8, 1'b0);
        chk("restart8_busy", busy8, 1'b1);
        repeat (18) @(posedge clk);
        #1 start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        wait_done(8);

        // reset in the middle of a run
        push_trace(8, 8, 8'hFF);
        pulse8();
        repeat (36) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", busy8, 1'b0);
        chk("midrst_enables", {rd8, wr8}, 2'b00);
        chk("midrst_status", {done8, fail8, faddr8, felem8, err8}, 0);
        chk("midrst_mem", {ma8, mwd8}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        push_trace(8, 8, 8'hFF);
        push_res(8, 1'b0, 0, 0, 0, 80);
        pulse8();
        wait_done(8);

        // non-power-of-two depth
        push_trace(5, 5, 8'h0F);
        push_res(5, 1'b0, 0, 0, 0, 50);
        pulse5();
        wait_done(5);

        chk("pending8_results", ex8.size(), 0);
        chk("pending5_results", ex5.size(), 0);
        chk("pending8_trace", tr8.size(), 0);
        chk("pending5_trace", tr5.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
